// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the SPI RAM command-port arbiter.
// Opcodes, FSM state encoding and command-word helper.
package ram_arb_pkg;

  localparam int CMD_W = 10;

  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WDATA = 2'b01;
  localparam logic [1:0] OP_RADDR = 2'b10;
  localparam logic [1:0] OP_RDATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    W_ADDR,
    W_DATA,
    R_ADDR,
    R_CMD,
    R_WAIT,
    DONE
  } state_t;

  function automatic logic [CMD_W-1:0] mk_cmd(
    input logic [1:0] op,
    input logic [7:0] pl
  );
    return {op, pl};
  endfunction

endpackage

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// Two-way round-robin picker; pointer register lives in the parent.
// Ports: req[1:0] requests, last = index granted last, gnt[1:0] one-hot grant.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = last ? 2'b01 : 2'b10;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Two-requester arbiter expanding read/write transactions into RAM commands.
// Ports: i_ARB_* requests/operands in, o_ARB_ack/rdata/err/busy out,
// o_ARB_ram_en/ram_data command out, i_ARB_ram_rdata/ram_valid read return.
// Optional read timeout enabled by defining RAM_ARB_TIMEOUT_EN.
module spi_ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             i_ARB_clk,
  input  logic             i_ARB_rst_n,
  input  logic [1:0]       i_ARB_req,
  input  logic [1:0]       i_ARB_we,
  input  logic [7:0]       i_ARB_addr0,
  input  logic [7:0]       i_ARB_addr1,
  input  logic [7:0]       i_ARB_wdata0,
  input  logic [7:0]       i_ARB_wdata1,
  output logic [1:0]       o_ARB_ack,
  output logic [7:0]       o_ARB_rdata,
  output logic             o_ARB_err,
  output logic             o_ARB_busy,
  output logic             o_ARB_ram_en,
  output logic [CMD_W-1:0] o_ARB_ram_data,
  input  logic [7:0]       i_ARB_ram_rdata,
  input  logic             i_ARB_ram_valid
);

  state_t           state_q, state_d;
  logic             last_q;
  logic             own_q;
  logic             we_q;
  logic [7:0]       addr_q;
  logic [7:0]       wdata_q;
  logic [1:0]       gnt;
  logic             sel_we;
  logic [7:0]       sel_addr;
  logic [7:0]       sel_wdata;
  logic [1:0]       ack_d;
  logic [7:0]       rdata_d;
  logic             err_d;
  logic             ram_en_d;
  logic [CMD_W-1:0] ram_data_d;
  logic             tmo;

  rr_arb2 u_rr (
    .req  (i_ARB_req),
    .last (last_q),
    .gnt  (gnt)
  );

  assign sel_we    = gnt[1] ? i_ARB_we[1] : i_ARB_we[0];
  assign sel_addr  = gnt[1] ? i_ARB_addr1 : i_ARB_addr0;
  assign sel_wdata = gnt[1] ? i_ARB_wdata1 : i_ARB_wdata0;

`ifdef RAM_ARB_TIMEOUT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge i_ARB_clk or negedge i_ARB_rst_n) begin
    if (!i_ARB_rst_n) begin
      cnt_q <= '0;
    end else if (state_q == R_CMD) begin
      cnt_q <= '0;
    end else if (state_q == R_WAIT) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign tmo = (cnt_q == 8'(TIMEOUT_CYC - 1));
`else
  logic unused_to;
  assign unused_to = ^TIMEOUT_CYC;
  assign tmo = 1'b0;
`endif

  // Outputs are decoded from the next state and registered,
  // so they line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    ack_d      = 2'b00;
    rdata_d    = 8'h00;
    err_d      = 1'b0;
    ram_en_d   = 1'b0;
    ram_data_d = '0;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          state_d    = sel_we ? W_ADDR : R_ADDR;
          ram_en_d   = 1'b1;
          ram_data_d = mk_cmd(sel_we ? OP_WADDR : OP_RADDR, sel_addr);
        end
      end
      W_ADDR: begin
        state_d    = W_DATA;
        ram_en_d   = 1'b1;
        ram_data_d = mk_cmd(OP_WDATA, wdata_q);
      end
      W_DATA: begin
        state_d = DONE;
        ack_d   = own_q ? 2'b10 : 2'b01;
      end
      R_ADDR: begin
        state_d    = R_CMD;
        ram_en_d   = 1'b1;
        ram_data_d = mk_cmd(OP_RDATA, 8'h00);
      end
      R_CMD: state_d = R_WAIT;
      R_WAIT: begin
        if (i_ARB_ram_valid) begin
          state_d = DONE;
          ack_d   = own_q ? 2'b10 : 2'b01;
          rdata_d = i_ARB_ram_rdata;
        end else if (tmo) begin
          state_d = DONE;
          ack_d   = own_q ? 2'b10 : 2'b01;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_ARB_clk or negedge i_ARB_rst_n) begin
    if (!i_ARB_rst_n) begin
      state_q        <= IDLE;
      last_q         <= 1'b1;
      own_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      o_ARB_ack      <= '0;
      o_ARB_rdata    <= '0;
      o_ARB_err      <= 1'b0;
      o_ARB_busy     <= 1'b0;
      o_ARB_ram_en   <= 1'b0;
      o_ARB_ram_data <= '0;
    end else begin
      state_q        <= state_d;
      o_ARB_ack      <= ack_d;
      o_ARB_rdata    <= rdata_d;
      o_ARB_err      <= err_d;
      o_ARB_busy     <= (state_d != IDLE);
      o_ARB_ram_en   <= ram_en_d;
      o_ARB_ram_data <= ram_data_d;
      if (state_q == IDLE && |gnt) begin
        own_q   <= gnt[1];
        last_q  <= gnt[1];
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
    end
  end

  logic unused_lat;
  assign unused_lat = ^{we_q, addr_q};

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scoreboard bench: arbiter paired with a behavioural 256x8 SPI RAM.
// Expected RAM commands and acks are queued; a negedge monitor checks them.
module tb_spi_ram_arbiter;

  typedef struct {
    int         own;
    logic [7:0] rdata;
    logic       err;
    int         cyc;
  } exp_ack_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = '0;
  logic [1:0] we = '0;
  logic [7:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic [1:0] ack;
  logic [7:0] rdata;
  logic       err;
  logic       busy;
  logic       ram_en;
  logic [9:0] ram_data;
  logic [7:0] ram_rdata = '0;
  logic       ram_valid = 1'b0;
  logic       ram_block = 1'b0;

  int cyc = 0;
  int nchk = 0;
  int npass = 0;
  logic [9:0] cmdq[$];
  exp_ack_t   ackq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef RAM_ARB_TIMEOUT_EN
  spi_ram_arbiter #(.TIMEOUT_CYC(4)) dut (
`else
  spi_ram_arbiter dut (
`endif
    .i_ARB_clk       (clk),
    .i_ARB_rst_n     (rst_n),
    .i_ARB_req       (req),
    .i_ARB_we        (we),
    .i_ARB_addr0     (addr0),
    .i_ARB_addr1     (addr1),
    .i_ARB_wdata0    (wdata0),
    .i_ARB_wdata1    (wdata1),
    .o_ARB_ack       (ack),
    .o_ARB_rdata     (rdata),
    .o_ARB_err       (err),
    .o_ARB_busy      (busy),
    .o_ARB_ram_en    (ram_en),
    .o_ARB_ram_data  (ram_data),
    .i_ARB_ram_rdata (ram_rdata),
    .i_ARB_ram_valid (ram_valid)
  );

  // Behavioural SPI RAM: read data returns one cycle after RDATA.
  logic [7:0] mem [256];
  logic [7:0] ram_wa = '0, ram_ra = '0;
  always @(posedge clk) begin
    ram_valid <= 1'b0;
    if (ram_en) begin
      case (ram_data[9:8])
        2'b00: ram_wa <= ram_data[7:0];
        2'b01: mem[ram_wa] <= ram_data[7:0];
        2'b10: ram_ra <= ram_data[7:0];
        default: begin
          ram_valid <= !ram_block;
          ram_rdata <= mem[ram_ra];
        end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_en) begin
        if (cmdq.size() == 0) chk("ram_cmd_extra", {54'd0, ram_data}, 64'h0);
        else chk("ram_cmd", {54'd0, ram_data}, {54'd0, cmdq.pop_front()});
      end
      if (ack != 2'b00) begin
        if (ackq.size() == 0) begin
          chk("ack_extra", {62'd0, ack}, 64'h0);
        end else begin
          exp_ack_t e;
          logic [1:0] eo;
          e = ackq.pop_front();
          eo = (e.own == 1) ? 2'b10 : 2'b01;
          chk("ack", {21'd0, ack, rdata, err, cyc},
              {21'd0, eo, e.rdata, e.err, e.cyc});
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(input int own);
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ack[own]) break;
    end
    #1;
    if (k == 60) chk("ack_wait", 64'h0, 64'h1);
  endtask

  task automatic push_w(input int own, input logic [7:0] a,
                        input logic [7:0] d, input int c);
    cmdq.push_back({2'b00, a});
    cmdq.push_back({2'b01, d});
    ackq.push_back('{own, 8'h00, 1'b0, c});
  endtask

  task automatic push_r(input int own, input logic [7:0] a,
                        input logic [7:0] d, input logic e, input int c);
    cmdq.push_back({2'b10, a});
    cmdq.push_back({2'b11, 8'h00});
    ackq.push_back('{own, d, e, c});
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {43'd0, ack, rdata, err, busy, ram_en, ram_data}, 64'h0);
  endtask

  int g;

  initial begin
    step(3);
    chk_zero("reset_outs");
    rst_n = 1'b1;
    step(1);
    chk_zero("idle_outs");

    // 1: req0 write 3C <= A5
    req = 2'b01; we = 2'b01; addr0 = 8'h3C; wdata0 = 8'hA5;
    g = cyc + 1;
    push_w(0, 8'h3C, 8'hA5, g + 2);
    step(1);
    chk("busy", {63'd0, busy}, 64'h1);
    wait_ack(0);
    req = 2'b00;
    step(1);

    // 2: req1 read 3C
    req = 2'b10; we = 2'b00; addr1 = 8'h3C;
    g = cyc + 1;
    push_r(1, 8'h3C, 8'hA5, 1'b0, g + 3);
    wait_ack(1);
    req = 2'b00;
    step(1);

    // 3: simultaneous after reset: req0 first, then req1 wins over held req0
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    req = 2'b11; we = 2'b01;
    addr0 = 8'h20; wdata0 = 8'h11; addr1 = 8'h3C;
    g = cyc + 1;
    push_w(0, 8'h20, 8'h11, g + 2);
    push_r(1, 8'h3C, 8'hA5, 1'b0, g + 7);
    push_r(0, 8'h20, 8'h11, 1'b0, g + 12);
    wait_ack(0);
    we = 2'b00;
    wait_ack(1);
    req = 2'b01;
    wait_ack(0);
    req = 2'b00;
    step(1);

    // 4: req0 held through ack with new operands
    req = 2'b01; we = 2'b01; addr0 = 8'h05; wdata0 = 8'h77;
    g = cyc + 1;
    push_w(0, 8'h05, 8'h77, g + 2);
    push_w(0, 8'h01, 8'h99, g + 6);
    wait_ack(0);
    addr0 = 8'h01; wdata0 = 8'h99;
    wait_ack(0);
    req = 2'b00;
    step(1);
    req = 2'b10; we = 2'b00; addr1 = 8'h05;
    g = cyc + 1;
    push_r(1, 8'h05, 8'h77, 1'b0, g + 3);
    wait_ack(1);
    req = 2'b00;
    step(1);
    req = 2'b10; addr1 = 8'h01;
    g = cyc + 1;
    push_r(1, 8'h01, 8'h99, 1'b0, g + 3);
    wait_ack(1);
    req = 2'b00;
    step(1);

    // 5: reset during R_CMD, then write/read 10
    req = 2'b10; we = 2'b00; addr1 = 8'h01;
    cmdq.push_back({2'b10, 8'h01});
    cmdq.push_back({2'b11, 8'h00});
    step(2);
    rst_n = 1'b0;
    req = 2'b00;
    #1;
    chk_zero("rst_mid");
    step(1);
    rst_n = 1'b1;
    step(2);
    req = 2'b01; we = 2'b01; addr0 = 8'h10; wdata0 = 8'h5A;
    g = cyc + 1;
    push_w(0, 8'h10, 8'h5A, g + 2);
    wait_ack(0);
    req = 2'b00;
    step(1);
    req = 2'b10; we = 2'b00; addr1 = 8'h10;
    g = cyc + 1;
    push_r(1, 8'h10, 8'h5A, 1'b0, g + 3);
    wait_ack(1);
    req = 2'b00;
    step(1);

`ifdef RAM_ARB_TIMEOUT_EN
    // 6: read timeout after 4 R_WAIT cycles
    ram_block = 1'b1;
    req = 2'b01; we = 2'b00; addr0 = 8'h10;
    g = cyc + 1;
    push_r(0, 8'h10, 8'h00, 1'b1, g + 6);
    wait_ack(0);
    req = 2'b00;
    ram_block = 1'b0;
    step(1);
`endif

    for (int i = 0; i < 20; i++) begin
      if (cmdq.size() == 0 && ackq.size() == 0) break;
      step(1);
    end
    chk("cmdq_left", 64'(cmdq.size()), 64'h0);
    chk("ackq_left", 64'(ackq.size()), 64'h0);
    step(2);
    chk_zero("final_idle");
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
